// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh dimensions, timestamp width and the packet flit format.
package noc_pkg;
  localparam int X_NODES = 4;
  localparam int Y_NODES = 4;
  localparam int X_W = $clog2(X_NODES);
  localparam int Y_W = $clog2(Y_NODES);
  localparam int TIMESTAMP_W = 32;
  localparam int CREATE_ANT_PERIOD = 200;
  localparam int ANT_PERIOD_W = $clog2(CREATE_ANT_PERIOD);
  typedef struct packed {
    logic [TIMESTAMP_W-1:0] timestamp;
    logic                   measure;
    logic                   ant;
    logic [X_W-1:0]         x_source;
    logic [Y_W-1:0]         y_source;
    logic [X_W-1:0]         x_dest;
    logic [Y_W-1:0]         y_dest;
    logic [15:0]            data;
  } packet_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer; caller guarantees push only when room (or popping) and pop only when non-empty.
module sync_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/eject_sink.sv
// eject_sink: router ejection endpoint; buffers data packets, drops ants, keeps rx/dest/latency statistics.
module eject_sink
  import noc_pkg::*;
#(
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0,
  parameter int DEPTH = 4,
  parameter int TS_W  = TIMESTAMP_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  input  logic [TS_W-1:0]  i_time,
  output packet_t          o_data,
  output logic             o_data_val,
  input  logic             i_rdy,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_ant_count,
  output logic [CNT_W-1:0] o_dest_err,
  output logic [CNT_W-1:0] o_lat_sum,
  output logic [TS_W-1:0]  o_lat_max,
  output logic             o_overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic is_data, push, pop, drop, full, empty, dest_bad;
  logic [CW-1:0] count, count_nx;
  logic [TS_W-1:0] lat;
  packet_t head;
  always_comb begin
    is_data  = i_data_val & ~i_data.ant;
    pop      = i_rdy & ~empty;
    push     = is_data & (~full | pop);
    drop     = is_data & full & ~pop;
    count_nx = count + CW'(push) - CW'(pop);
    dest_bad = (i_data.x_dest != X_W'(X_LOC)) | (i_data.y_dest != Y_W'(Y_LOC));
    lat      = i_time - TS_W'(i_data.timestamp);
  end
  sync_fifo #(.T(packet_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(i_data),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  assign o_data_val = ~empty;
  assign o_data     = empty ? '0 : head;
  // Enable leaves one slot free for the packet the router may already have launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_en        <= 1'b0;
      o_overflow  <= 1'b0;
      o_rx_count  <= '0;
      o_ant_count <= '0;
      o_dest_err  <= '0;
      o_lat_sum   <= '0;
      o_lat_max   <= '0;
    end else begin
      o_en       <= count_nx <= CW'(DEPTH - 2);
      o_overflow <= o_overflow | drop;
      if (i_clear) begin
        o_rx_count  <= '0;
        o_ant_count <= '0;
        o_dest_err  <= '0;
        o_lat_sum   <= '0;
        o_lat_max   <= '0;
      end else if (i_data_val) begin
        o_rx_count  <= o_rx_count + CNT_W'(is_data & (o_rx_count != '1));
        o_ant_count <= o_ant_count + CNT_W'(i_data.ant & (o_ant_count != '1));
        o_dest_err  <= o_dest_err + CNT_W'(dest_bad & (o_dest_err != '1));
        if (is_data & i_data.measure) begin
          o_lat_sum <= o_lat_sum + CNT_W'(lat);
          o_lat_max <= lat > o_lat_max ? lat : o_lat_max;
        end
      end
    end
  end
endmodule

// File: doc/eject_sink.md
# eject_sink

Ejection-side endpoint for one router output port: the receiving end of the packet injection interface a node uses toward the router. It accepts `packet_t` flits from a router output (`o_data`/`o_data_val`), applies backpressure to that router through a one-bit enable, and buffers packets for the local node. On each accepted packet it checks that the destination matches its own coordinates, counts data and ant packets, and accumulates latency statistics. One instance sits on the local (ejection) port of each mesh router, and all instances are readable by the test harness.

## Interface
- `X_LOC`, default 0: column of the owning router.
- `Y_LOC`, default 0: row of the owning router.
- `DEPTH`, default 4: FIFO entries; a power of two, at least 4.
- `TS_W`, default 32: timestamp and latency width.
- `CNT_W`, default 32: width of each statistics counter.

Ports:
- `clk` in 1: system clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_data` in `packet_t`: packet from the router output port.
- `i_data_val` in 1: `i_data` is valid this cycle.
- `o_en` out 1: to the router's `i_en`; this sink can take a packet next cycle.
- `i_time` in `TS_W`: global cycle counter, the same clock as the packet `timestamp` field.
- `o_data` out `packet_t`: head-of-FIFO packet toward the node.
- `o_data_val` out 1: `o_data` is valid.
- `i_rdy` in 1: node consumes the head when `o_data_val & i_rdy`.
- `i_clear` in 1: zero all statistics; FIFO unaffected.
- `o_rx_count` out `CNT_W`: data packets accepted.
- `o_ant_count` out `CNT_W`: ant packets accepted (consumed, not forwarded).
- `o_dest_err` out `CNT_W`: accepted packets whose `x_dest`/`y_dest` differ from `X_LOC`/`Y_LOC`.
- `o_lat_sum` out `CNT_W`: sum of latencies of measured packets.
- `o_lat_max` out `TS_W`: largest single latency seen.
- `o_overflow` out 1: sticky flag; a packet arrived while the FIFO was full.

## Operation
- Accept condition: `i_data_val` high at a rising edge. Every accepted packet is classified in that cycle.
- Ant packet (`ant`=1):
  - `o_ant_count` increments.
  - The packet is not enqueued.
  - The destination check still applies.
- Data packet (`ant`=0):
  - Enqueued if the FIFO is not full.
  - If the FIFO is full, the packet is dropped, `o_overflow` sets and stays set until `reset`, and `o_rx_count` still increments.
- Destination mismatch: `o_dest_err` increments; the packet is otherwise handled normally.
- Latency (data packets with `measure`=1 only):
  - lat = `i_time` − `timestamp`, computed modulo 2^`TS_W`, so wrap-around is handled.
  - `o_lat_sum` adds lat zero-extended to `CNT_W`, wrapping on overflow.
  - `o_lat_max` = max(`o_lat_max`, lat).
- Counters saturate at all-ones rather than wrapping; `o_lat_sum` is the exception and wraps.
- `i_clear` zeroes all counters, `o_lat_sum` and `o_lat_max`. When `i_clear` coincides with an accept, the clear wins and that packet is not counted.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of `log2(DEPTH)+1` bits.
  - Enqueue and dequeue in the same cycle keep the occupancy unchanged, and this is legal even when the FIFO is full.
- Enable: `o_en` = (occupancy after this edge) ≤ `DEPTH`−2. This leaves one slot for the packet already in flight, since the router samples `o_en` and sends one cycle later. Overflow therefore signals a router protocol violation.
- Dequeue: `o_data_val` = FIFO not empty. `o_data` shows the head entry and holds stable while `o_data_val & ~i_rdy`.

## Timing
- Reset values: `o_en`=0 during `reset`, then 1 on the first cycle after reset deasserts. `o_data_val`=0, `o_data`='0, all counters 0, `o_overflow`=0.
- A packet accepted at edge k appears on `o_data`/`o_data_val` after edge k, i.e. the cycle after acceptance, provided the FIFO was empty. Minimum latency is 1 cycle.
- `o_en` is registered and reflects the state after edge k in the following cycle.
- Statistics outputs are registered and update one cycle after acceptance.
- Asserting `reset` mid-stream empties the FIFO and discards all buffered packets. No partial counter updates occur in that cycle.

## Structure
- `packet_t`, `X_NODES`, `Y_NODES`, the `CREATE_ANT_PERIOD`-related constants and the timestamp width belong in the shared `noc_pkg`. This replaces the include-file macros for new RTL.
- One sub-module: `sync_fifo` (parameters `T`, `DEPTH`), providing `full`, `empty`, `count`, `push`, `pop` and `head`. Classification, the statistics datapath and the enable logic stay in `eject_sink`.

## Test plan
- Reset then idle: with `reset` high for 2 cycles, `o_en`=0, `o_data_val`=0 and all counters are 0; `o_en` reads 1 on the first cycle after reset deasserts.
- Single data packet: `X_LOC`=2, `Y_LOC`=1, dest (2,1), `measure`=1, `timestamp`=100, `i_time`=107 → `o_data_val` next cycle, `o_rx_count`=1, `o_lat_sum`=7, `o_lat_max`=7.
- Backpressure: `i_rdy`=0 with 3 packets sent at `DEPTH`=4 → `o_en` drops after occupancy reaches 3. A 4th in-flight packet is accepted with no overflow. Then `i_rdy`=1 drains all 4 in order.
- Overflow: 5 back-to-back packets with `o_en` ignored and `i_rdy`=0 → `o_overflow`=1, `o_rx_count`=5, 4 packets delivered.
- Ant and error mix: an ant packet to (2,1) plus a data packet to (0,0) → `o_ant_count`=1, `o_dest_err`=1, only the data packet appears on `o_data`.
- Wrap and clear: `timestamp`=0xFFFF_FFFE, `i_time`=3 → latency 5. Then `i_clear` together with an accept → every statistic reads 0.
